// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register carrying instr/pc/exc/bd, with redirect bubbles for req/eret/flush.
// Define PIPE_SKID_EN for the 2-entry skid buffer with registered in_ready; otherwise a single slot.
module pipe_stage_reg #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned EXC_W      = 5,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [31:0]       in_pc,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [31:0]       out_pc,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd,
    input  logic              flush,
    input  logic              req,
    input  logic              eret,
    input  logic [31:0]       epc,
    input  logic              eret_bd,
    output logic [1:0]        occ
);

    logic              main_valid;
    logic [DATA_W-1:0] main_instr;
    logic [31:0]       main_pc;
    logic [EXC_W-1:0]  main_exc;
    logic              main_bd;

    logic              skid_valid;
    logic [DATA_W-1:0] skid_instr;
    logic [31:0]       skid_pc;
    logic [EXC_W-1:0]  skid_exc;
    logic              skid_bd;

    logic redirect;
    logic accept;
    logic emit;
    logic main_free;
    logic take_skid;

    assign redirect  = req | eret | flush;
    assign emit      = main_valid & out_ready;
    assign main_free = emit | ~main_valid;
    assign accept    = in_valid & in_ready;

`ifdef PIPE_SKID_EN
    // in_ready depends only on the skid register, so out_ready never reaches it.
    assign in_ready  = ~skid_valid & ~redirect & ~reset;
    assign take_skid = skid_valid & main_free;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            skid_exc   <= '0;
            skid_bd    <= 1'b0;
        end else if (redirect) begin
            skid_valid <= 1'b0;
        end else if (accept && !main_free) begin
            skid_valid <= 1'b1;
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
            skid_exc   <= in_exc;
            skid_bd    <= in_bd;
        end else if (take_skid) begin
            skid_valid <= 1'b0;
        end
    end
`else
    assign in_ready   = main_free & ~redirect & ~reset;
    assign take_skid  = 1'b0;
    assign skid_valid = 1'b0;
    assign skid_instr = '0;
    assign skid_pc    = '0;
    assign skid_exc   = '0;
    assign skid_bd    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_instr <= '0;
            main_pc    <= RESET_PC;
            main_exc   <= '0;
            main_bd    <= 1'b0;
        end else if (req) begin
            main_valid <= 1'b0;
            main_instr <= '0;
            main_pc    <= HANDLER_PC;
            main_exc   <= '0;
            main_bd    <= 1'b0;
        end else if (eret) begin
            main_valid <= 1'b0;
            main_instr <= '0;
            main_pc    <= epc;
            main_exc   <= '0;
            main_bd    <= eret_bd;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_instr <= '0;
            main_pc    <= '0;
            main_exc   <= '0;
            main_bd    <= 1'b0;
        end else if (take_skid) begin
            main_valid <= 1'b1;
            main_instr <= skid_instr;
            main_pc    <= skid_pc;
            main_exc   <= skid_exc;
            main_bd    <= skid_bd;
        end else if (accept && main_free) begin
            main_valid <= 1'b1;
            main_instr <= in_instr;
            main_pc    <= in_pc;
            main_exc   <= in_exc;
            main_bd    <= in_bd;
        end else if (emit) begin
            // Drained: keep pc/bd visible as a bubble until the next beat lands.
            main_valid <= 1'b0;
        end
    end

    assign out_valid = main_valid;
    assign out_instr = main_instr;
    assign out_pc    = main_pc;
    assign out_exc   = main_exc;
    assign out_bd    = main_bd;
    assign occ       = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed beats are queued on accept, a negedge monitor checks emits.
// Expectations for occupancy and in_ready follow PIPE_SKID_EN when it is defined.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  in_exc;
    logic        in_bd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [4:0]  out_exc;
    logic        out_bd;
    logic        flush;
    logic        req;
    logic        eret;
    logic [31:0] epc;
    logic        eret_bd;
    logic [1:0]  occ;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  exc;
        logic        bd;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W(32),
        .EXC_W(5),
        .RESET_PC(32'h0000_3000),
        .HANDLER_PC(32'h0000_4180)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc), .in_bd(in_bd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_exc(out_exc), .out_bd(out_bd),
        .flush(flush), .req(req), .eret(eret), .epc(epc), .eret_bd(eret_bd),
        .occ(occ)
    );

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input int unsigned i);
        beat_t b;
        b.instr = 32'hA500_0000 | i;
        b.pc    = 32'h0000_3000 + 4 * i;
        b.exc   = 5'(i);
        b.bd    = i[0];
        return b;
    endfunction

    task automatic drive(input beat_t b, input logic v);
        in_valid = v;
        in_instr = b.instr;
        in_pc    = b.pc;
        in_exc   = b.exc;
        in_bd    = b.bd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every emitted beat must match the oldest outstanding accepted beat.
    always @(negedge clk) begin
        beat_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("emit_unexpected", 70'(out_valid), 70'(0));
            end else begin
                e = sb.pop_front();
                check("emit", {out_instr, out_pc, out_exc, out_bd}, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0; in_exc = '0; in_bd = 1'b0;
        req = 1'b0; eret = 1'b0; flush = 1'b0; epc = '0; eret_bd = 1'b0;

        @(negedge clk);
        check("rst_valid", 70'(out_valid), 70'(0));
        check("rst_pc",    70'(out_pc),    70'(32'h3000));
        check("rst_instr", 70'(out_instr), 70'(0));
        check("rst_exc",   70'(out_exc),   70'(0));
        check("rst_bd",    70'(out_bd),    70'(0));
        check("rst_occ",   70'(occ),       70'(0));
        check("rst_ready", 70'(in_ready),  70'(0));
        tick();
        reset = 1'b0;

        // Streaming with out_ready=1: one beat per cycle, 1-cycle latency.
        for (int unsigned i = 0; i < 4; i++) begin
            drive(mk(i), 1'b1);
            @(negedge clk);
            check("stream_ready", 70'(in_ready), 70'(1));
            sb.push_back(mk(i));
            if (i > 0) begin
                check("stream_valid", 70'(out_valid), 70'(1));
                check("stream_pc",    70'(out_pc),    70'(32'h3000 + 4 * (i - 1)));
                check("stream_occ",   70'(occ),       70'(1));
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_tail_occ", 70'(occ), 70'(1));
        tick();
        @(negedge clk);
        check("stream_empty_valid", 70'(out_valid), 70'(0));
        check("stream_empty_occ",   70'(occ),       70'(0));
        tick();

        // Backpressure.
        out_ready = 1'b0;
        drive(mk(4), 1'b1);
        @(negedge clk);
        check("bp0_ready", 70'(in_ready), 70'(1));
        check("bp0_occ",   70'(occ),      70'(0));
        sb.push_back(mk(4));
        tick();
        drive(mk(5), 1'b1);
        @(negedge clk);
        check("bp1_occ", 70'(occ), 70'(1));
`ifdef PIPE_SKID_EN
        check("bp1_ready", 70'(in_ready), 70'(1));
        sb.push_back(mk(5));
        tick();
        drive(mk(6), 1'b1);
        @(negedge clk);
        check("bp2_ready", 70'(in_ready), 70'(0));
        check("bp2_occ",   70'(occ),      70'(2));
        tick();
        @(negedge clk);
        check("bp3_ready", 70'(in_ready), 70'(0));
        check("bp3_occ",   70'(occ),      70'(2));
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("drain0_ready", 70'(in_ready), 70'(0));
        check("drain0_occ",   70'(occ),      70'(2));
        tick();
        @(negedge clk);
        check("drain1_ready", 70'(in_ready), 70'(1));
        check("drain1_occ",   70'(occ),      70'(1));
        tick();
`else
        check("bp1_ready", 70'(in_ready), 70'(0));
        tick();
        @(negedge clk);
        check("bp2_ready", 70'(in_ready), 70'(0));
        check("bp2_occ",   70'(occ),      70'(1));
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("drain0_ready", 70'(in_ready), 70'(1));
        check("drain0_occ",   70'(occ),      70'(1));
        tick();
`endif
        @(negedge clk);
        check("drained_occ", 70'(occ), 70'(0));
        tick();

        // Exception entry while full, with a beat on offer.
        out_ready = 1'b0;
        drive(mk(7), 1'b1);
        @(negedge clk);
        check("req_fill0_ready", 70'(in_ready), 70'(1));
        sb.push_back(mk(7));
        tick();
`ifdef PIPE_SKID_EN
        drive(mk(8), 1'b1);
        @(negedge clk);
        check("req_fill1_ready", 70'(in_ready), 70'(1));
        sb.push_back(mk(8));
        tick();
`endif
        drive(mk(9), 1'b1);
        req = 1'b1;
        @(negedge clk);
        check("req_ready", 70'(in_ready), 70'(0));
`ifdef PIPE_SKID_EN
        check("req_occ_full", 70'(occ), 70'(2));
`else
        check("req_occ_full", 70'(occ), 70'(1));
`endif
        tick();
        req = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        sb.delete();
        check("req_valid", 70'(out_valid), 70'(0));
        check("req_pc",    70'(out_pc),    70'(32'h4180));
        check("req_exc",   70'(out_exc),   70'(0));
        check("req_bd",    70'(out_bd),    70'(0));
        check("req_instr", 70'(out_instr), 70'(0));
        check("req_occ",   70'(occ),       70'(0));
        tick();
        @(negedge clk);
        check("req_not_consumed", 70'(out_valid), 70'(0));
        tick();

        // ERET coinciding with an emit.
        out_ready = 1'b0;
        drive(mk(10), 1'b1);
        @(negedge clk);
        check("eret_fill_ready", 70'(in_ready), 70'(1));
        sb.push_back(mk(10));
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        eret = 1'b1; epc = 32'h0000_3040; eret_bd = 1'b1;
        @(negedge clk);
        check("eret_ready", 70'(in_ready), 70'(0));
        tick();
        eret = 1'b0;
        @(negedge clk);
        check("eret_valid", 70'(out_valid), 70'(0));
        check("eret_pc",    70'(out_pc),    70'(32'h3040));
        check("eret_bd",    70'(out_bd),    70'(1));
        check("eret_instr", 70'(out_instr), 70'(0));
        check("eret_occ",   70'(occ),       70'(0));
        tick();
        @(negedge clk);
        check("eret_hold_pc", 70'(out_pc), 70'(32'h3040));
        check("eret_hold_bd", 70'(out_bd), 70'(1));
        tick();
        drive(mk(11), 1'b1);
        @(negedge clk);
        check("eret_next_ready", 70'(in_ready), 70'(1));
        sb.push_back(mk(11));
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("eret_overwrite_pc", 70'(out_pc), 70'(32'h302C));
        tick();

        // Flush alone, then combined redirects.
        flush = 1'b1;
        @(negedge clk);
        check("flush_ready", 70'(in_ready), 70'(0));
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush_pc",    70'(out_pc),    70'(0));
        check("flush_bd",    70'(out_bd),    70'(0));
        check("flush_valid", 70'(out_valid), 70'(0));
        tick();
        req = 1'b1; flush = 1'b1;
        tick();
        req = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("req_flush_pc", 70'(out_pc), 70'(32'h4180));
        tick();
        eret = 1'b1; flush = 1'b1; epc = 32'h1234_5678; eret_bd = 1'b0;
        tick();
        eret = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("eret_flush_pc", 70'(out_pc), 70'(32'h1234_5678));
        check("eret_flush_bd", 70'(out_bd), 70'(0));
        tick();

        // Asynchronous reset mid-cycle while holding beats.
        out_ready = 1'b0;
        drive(mk(12), 1'b1);
        @(negedge clk);
        check("ar_fill0_ready", 70'(in_ready), 70'(1));
        sb.push_back(mk(12));
        tick();
`ifdef PIPE_SKID_EN
        drive(mk(13), 1'b1);
        @(negedge clk);
        check("ar_fill1_ready", 70'(in_ready), 70'(1));
        sb.push_back(mk(13));
        tick();
`endif
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("ar_valid", 70'(out_valid), 70'(0));
        check("ar_pc",    70'(out_pc),    70'(32'h3000));
        check("ar_instr", 70'(out_instr), 70'(0));
        check("ar_occ",   70'(occ),       70'(0));
        check("ar_ready", 70'(in_ready),  70'(0));
        sb.delete();
        reset = 1'b0;
        tick();
        out_ready = 1'b1;
        drive(mk(14), 1'b1);
        @(negedge clk);
        check("ar_after_ready", 70'(in_ready), 70'(1));
        check("ar_after_valid", 70'(out_valid), 70'(0));
        sb.push_back(mk(14));
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("ar_after_occ", 70'(occ), 70'(1));
        tick();
        @(negedge clk);
        check("sb_drained", 70'(sb.size()), 70'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
